gf251_inv_16: RTL and testbench

GF251_INV_16 -- requirements
Module: gf251_inv_16

---
 rtl/gf251_inv_16_pkg.sv | 21 ++
 rtl/gf251_mul_8.sv | 22 ++
 rtl/gf251_inv_16.sv | 107 ++++++++++
 tb/tb_gf251_inv_16.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/gf251_inv_16_pkg.sv
// rtl/gf251_inv_16_pkg.sv - shared constants, FSM states and lane reduction for the GF(251) inverter
package gf251_inv_16_pkg;

    localparam int         LANE_W        = 8;
    localparam logic [7:0] GF251_P       = 8'd251;
    localparam logic [7:0] GF251_INV_EXP = 8'd249;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SQR,
        MUL,
        DONE
    } state_t;

    // Byte inputs exceed the modulus by at most 4, so one conditional subtract suffices.
    function automatic logic [7:0] reduce_p(input logic [7:0] v);
        return (v >= GF251_P) ? v - GF251_P : v;
    endfunction

endpackage

// File: rtl/gf251_mul_8.sv
// rtl/gf251_mul_8.sv - combinational 8x8 multiply reduced mod 251
module gf251_mul_8
    import gf251_inv_16_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] p
);

    logic [15:0] prod;
    logic [10:0] fold1;
    logic [8:0]  fold2;

    // 256 == 5 (mod 251): fold the high byte down twice, then one final subtract.
    always_comb begin
        prod  = 16'(a) * 16'(b);
        fold1 = 11'(prod[15:8]) * 11'd5 + 11'(prod[7:0]);
        fold2 = 9'(fold1[10:8]) * 9'd5 + 9'(fold1[7:0]);
        p     = (fold2 >= 9'(GF251_P)) ? 8'(fold2 - 9'(GF251_P)) : fold2[7:0];
    end

endmodule

// File: rtl/gf251_inv_16.sv
// rtl/gf251_inv_16.sv - multi-lane GF(251) Fermat inverter; GF251_INV_ZERO_FLAG_EN adds o_zero
module gf251_inv_16
    import gf251_inv_16_pkg::*;
#(
    parameter int LANES = 2
)
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [LANE_W*LANES-1:0]   i_x,
    output logic [LANE_W*LANES-1:0]   o_o,
    output logic                      o_done,
    output logic                      o_busy
`ifdef GF251_INV_ZERO_FLAG_EN
    ,
    output logic [LANES-1:0]          o_zero
`endif
);

    localparam int W = LANE_W * LANES;

    state_t         state;
    logic [W-1:0]   acc;
    logic [W-1:0]   base;
    logic [W-1:0]   base_red;
    logic [W-1:0]   prod;
    logic [2:0]     idx;

    // One multiplier per lane: squares in SQR, multiplies by the base in MUL.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [LANE_W-1:0] mul_b;

        assign base_red[k*LANE_W +: LANE_W] = reduce_p(base[k*LANE_W +: LANE_W]);
        assign mul_b = (state == MUL) ? base[k*LANE_W +: LANE_W] : acc[k*LANE_W +: LANE_W];

        gf251_mul_8 u_mul (
            .a (acc[k*LANE_W +: LANE_W]),
            .b (mul_b),
            .p (prod[k*LANE_W +: LANE_W])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            acc    <= '0;
            base   <= '0;
            idx    <= '0;
            o_o    <= '0;
            o_done <= 1'b0;
            o_busy <= 1'b0;
`ifdef GF251_INV_ZERO_FLAG_EN
            o_zero <= '0;
`endif
        end else begin
            o_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        base   <= i_x;
                        o_busy <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    acc   <= base_red;
                    base  <= base_red;
                    idx   <= 3'd6;
                    state <= SQR;
                end
                SQR: begin
                    acc <= prod;
                    if (GF251_INV_EXP[idx]) begin
                        state <= MUL;
                    end else if (idx == 3'd0) begin
                        state <= DONE;
                    end else begin
                        idx <= idx - 3'd1;
                    end
                end
                MUL: begin
                    acc <= prod;
                    if (idx == 3'd0) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx - 3'd1;
                        state <= SQR;
                    end
                end
                DONE: begin
                    o_o    <= acc;
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
`ifdef GF251_INV_ZERO_FLAG_EN
                    for (int k = 0; k < LANES; k++) begin
                        o_zero[k] <= (base[k*LANE_W +: LANE_W] == '0);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf251_inv_16.sv
// tb/tb_gf251_inv_16.sv - randomized self-checking bench against a brute-force GF(251) inverse model
module tb_gf251_inv_16;

    localparam int LANES = 2;
    localparam int W     = 8 * LANES;

    logic          i_clk;
    logic          i_rst;
    logic          i_start;
    logic [W-1:0]  i_x;
    logic [W-1:0]  o_o;
    logic          o_done;
    logic          o_busy;
`ifdef GF251_INV_ZERO_FLAG_EN
    logic [LANES-1:0] o_zero;
`endif

    int checks = 0;
    int errors = 0;

    gf251_inv_16 #(.LANES(LANES)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_x     (i_x),
        .o_o     (o_o),
        .o_done  (o_done),
        .o_busy  (o_busy)
`ifdef GF251_INV_ZERO_FLAG_EN
        ,
        .o_zero  (o_zero)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inverse found by search: the y in 1..250 with r*y == 1 (mod 251).
    function automatic int inv_ref(input int v);
        int r;
        r = v % 251;
        if (r == 0) return 0;
        for (int y = 1; y < 251; y++) begin
            if ((r * y) % 251 == 1) return y;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] model_inv(input logic [W-1:0] x);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) r[k*8 +: 8] = 8'(inv_ref(int'(x[k*8 +: 8])));
        return r;
    endfunction

    function automatic logic [LANES-1:0] model_zero(input logic [W-1:0] x);
        logic [LANES-1:0] z;
        for (int k = 0; k < LANES; k++) z[k] = (int'(x[k*8 +: 8]) % 251 == 0);
        return z;
    endfunction

    // Called at #1 after an edge with the DUT idle; returns one cycle after o_done.
    task automatic run_op(input logic [W-1:0] x, input bit poke_done, output logic [W-1:0] res);
        int lat;
        int busy_n;
        i_x     = x;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_x     = W'($urandom);
        lat     = 0;
        busy_n  = o_busy ? 1 : 0;
        while (!o_done && lat < 40) begin
            @(posedge i_clk); #1;
            lat++;
            if (!o_done && o_busy) busy_n++;
            i_start = poke_done && (lat == 13);
        end
        i_start = 1'b0;
        res = o_o;
        check("latency", 64'(lat), 64'd14);
        check("busy_cycles", 64'(busy_n), 64'd14);
        check("busy_at_done", 64'(o_busy), 64'd0);
        @(posedge i_clk); #1;
        check("done_pulse", 64'(o_done), 64'd0);
        check("busy_after", 64'(o_busy), 64'd0);
        check("o_hold", 64'(o_o), 64'(res));
    endtask

    initial begin
        logic [W-1:0] res;
        logic [W-1:0] x;
        int           ndone;
        int           r;

        i_rst   = 1'b1;
        i_start = 1'b0;
        i_x     = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_o", 64'(o_o), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
`ifdef GF251_INV_ZERO_FLAG_EN
        check("rst_zero", 64'(o_zero), 64'd0);
`endif
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        run_op(16'h0203, 1'b0, res);
        check("x0203", 64'(res), 64'h7E54);
        run_op(16'h2244, 1'b1, res);
        check("x2244", 64'(res), 64'h6030);
        run_op(16'h01FA, 1'b0, res);
        check("x01FA", 64'(res), 64'h01FA);
        run_op(16'h00FC, 1'b0, res);
        check("x00FC", 64'(res), 64'h0001);
`ifdef GF251_INV_ZERO_FLAG_EN
        check("zero_00FC", 64'(o_zero), 64'(2'b10));
`endif

        // Start while busy must be ignored.
        i_x = 16'h0203; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (4) begin @(posedge i_clk); #1; end
        i_x = 16'h2244; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        ndone = 0;
        res   = '0;
        repeat (30) begin
            @(posedge i_clk); #1;
            if (o_done) begin ndone++; res = o_o; end
        end
        check("busy_ign_done", 64'(ndone), 64'd1);
        check("busy_ign_o", 64'(res), 64'h7E54);

        // Reset mid-operation aborts with no o_done.
        i_x = 16'h2244; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (6) begin @(posedge i_clk); #1; end
        i_rst = 1'b1; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_start = 1'b0;
        check("abort_busy", 64'(o_busy), 64'd0);
        check("abort_o", 64'(o_o), 64'd0);
        ndone = 0;
        repeat (25) begin
            @(posedge i_clk); #1;
            if (o_done) ndone++;
        end
        check("abort_nodone", 64'(ndone), 64'd0);
        run_op(16'h2244, 1'b0, res);
        check("after_abort", 64'(res), 64'h6030);

        repeat (20) begin
            x = W'($urandom);
            run_op(x, 1'b0, res);
            check("rand", 64'(res), 64'(model_inv(x)));
`ifdef GF251_INV_ZERO_FLAG_EN
            check("rand_zero", 64'(o_zero), 64'(model_zero(x)));
`endif
        end

        for (int v = 0; v < 256; v++) begin
            x = {8'($urandom), 8'(v)};
            run_op(x, 1'b0, res);
            check("sweep", 64'(res), 64'(model_inv(x)));
            r = v % 251;
            if (r != 0) check("sweep_prod", 64'((r * int'(res[7:0])) % 251), 64'd1);
`ifdef GF251_INV_ZERO_FLAG_EN
            check("sweep_zero", 64'(o_zero), 64'(model_zero(x)));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
